// File: rtl/control_unit.sv
// Hardwired Moore control unit sequencing fetch, decode and multi-cycle execute for the datapath.
// Optional build macro CU_MEM_WAIT_EN: RAM states stall until mem_ready is sampled high.
module control_unit #(
    parameter logic [4:0] OP_INC = 5'd14,
    parameter logic [4:0] OP_ADD = 5'd3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic [4:0]  Control_Signals,
    output logic        run
);

    localparam int unsigned EN_Z   = 18;
    localparam int unsigned EN_PC  = 20;
    localparam int unsigned EN_MDR = 21;
    localparam int unsigned EN_CON = 22;
    localparam int unsigned EN_IR  = 24;
    localparam int unsigned EN_MAR = 25;
    localparam int unsigned EN_Y   = 26;

    localparam int unsigned BS_GPR = 0;
    localparam int unsigned BS_Z   = 19;
    localparam int unsigned BS_PC  = 20;
    localparam int unsigned BS_MDR = 21;
    localparam int unsigned BS_C   = 23;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10100;
    localparam logic [4:0] OPC_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] op;
    logic       is_alu;
    logic       is_mem;
    logic       mem_stall;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign is_alu    = (op == OPC_ADD) || (op == OPC_SUB) || (op == OPC_AND) || (op == OPC_OR);
    assign is_mem    = (op == OPC_LD) || (op == OPC_ST);
    assign unused_ir = ^ir[26:0];

`ifdef CU_MEM_WAIT_EN
    assign mem_stall = ~mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_stall        = 1'b0;
`endif

    // State register; reset drops straight to RESET so no partial write can complete
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_RESET;
        else      state <= state_next;
    end

    // Next-state sequencing by opcode
    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = mem_stall ? S_T1 : S_T2;
            S_T2:    state_next = S_T3;
            S_T3: begin
                if (is_alu || is_mem || op == OPC_ADDI || op == OPC_BR) state_next = S_T4;
                else if (op == OPC_HALT)                               state_next = S_HALT;
                else                                                   state_next = S_T0;
            end
            S_T4:    state_next = S_T5;
            S_T5:    state_next = is_mem || (op == OPC_BR) ? S_T6 : S_T0;
            S_T6: begin
                if (op == OPC_LD)      state_next = mem_stall ? S_T6 : S_T7;
                else if (op == OPC_ST) state_next = S_T7;
                else                   state_next = S_T0;
            end
            S_T7:    state_next = (op == OPC_ST && mem_stall) ? S_T7 : S_T0;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    // Moore decode from state and ir; con_ff only gates PCin in br T6
    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        Control_Signals = '0;
        run             = 1'b1;
        case (state)
            S_T0: begin
                busSelect[BS_PC] = 1'b1;
                enable[EN_MAR]   = 1'b1;
                enable[EN_Z]     = 1'b1;
                Control_Signals  = OP_INC;
            end
            S_T1: begin
                busSelect[BS_Z] = 1'b1;
                enable[EN_PC]   = 1'b1;
                enable[EN_MDR]  = 1'b1;
                MD_Read         = 1'b1;
                ReadRAM         = 1'b1;
            end
            S_T2: begin
                busSelect[BS_MDR] = 1'b1;
                enable[EN_IR]     = 1'b1;
            end
            S_T3: begin
                if (is_alu || op == OPC_ADDI) begin
                    Grb = 1'b1; Rout = 1'b1; busSelect[BS_GPR] = 1'b1; enable[EN_Y] = 1'b1;
                end else if (is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; enable[EN_Y] = 1'b1;
                end else if (op == OPC_JR) begin
                    Gra = 1'b1; Rout = 1'b1; busSelect[BS_GPR] = 1'b1; enable[EN_PC] = 1'b1;
                end else if (op == OPC_BR) begin
                    Gra = 1'b1; Rout = 1'b1; busSelect[BS_GPR] = 1'b1; enable[EN_CON] = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; busSelect[BS_GPR] = 1'b1;
                    Control_Signals = op; enable[EN_Z] = 1'b1;
                end else if (is_mem || op == OPC_ADDI) begin
                    busSelect[BS_C] = 1'b1; Control_Signals = OP_ADD; enable[EN_Z] = 1'b1;
                end else if (op == OPC_BR) begin
                    busSelect[BS_PC] = 1'b1; enable[EN_Y] = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu || op == OPC_ADDI) begin
                    busSelect[BS_Z] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_mem) begin
                    busSelect[BS_Z] = 1'b1; enable[EN_MAR] = 1'b1;
                end else if (op == OPC_BR) begin
                    busSelect[BS_C] = 1'b1; Control_Signals = OP_ADD; enable[EN_Z] = 1'b1;
                end
            end
            S_T6: begin
                if (op == OPC_LD) begin
                    MD_Read = 1'b1; ReadRAM = 1'b1; enable[EN_MDR] = 1'b1;
                end else if (op == OPC_ST) begin
                    Gra = 1'b1; Rout = 1'b1; busSelect[BS_GPR] = 1'b1; enable[EN_MDR] = 1'b1;
                end else if (op == OPC_BR) begin
                    busSelect[BS_Z] = 1'b1; enable[EN_PC] = con_ff;
                end
            end
            S_T7: begin
                if (op == OPC_LD) begin
                    busSelect[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OPC_ST) begin
                    WriteRAM = 1'b1;
                end
            end
            default: run = 1'b0;
        endcase
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control unit that sequences the Phase 2 datapath: instruction fetch, decode and multi-cycle execute for the supported instruction subset. Every datapath strobe comes from this block: register-file select (Gra/Grb/Grc, Rin, Rout, BAout), special-register enables, bus source select, ALU op, and RAM/MDR control. It sits beside `datapath` and takes only the instruction register and branch-condition flag back from it.

## Interface
- `OP_INC`, 14, ALU op code that produces PC+1.
- `OP_ADD`, 3, ALU op code used for address and immediate addition.
- `clk` in 1: single clock; all state changes on the rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `ir` in 32: instruction register contents; opcode is `ir[31:27]`.
- `con_ff` in 1: branch condition flip-flop from the datapath.
- `mem_ready` in 1: RAM access complete; used only when `CU_MEM_WAIT_EN` is defined.
- `enable` out 32: register load enables.
  - bit 18 Zin, 20 PCin, 21 MDRin, 22 CONin, 24 IRin, 25 MARin, 26 Yin.
  - All other bits are 0.
- `busSelect` out 32: one-hot bus source.
  - bit 0 selected GPR (with Rout), 19 Zlo, 20 PC, 21 MDR, 23 C (sign-extended `ir[18:0]`).
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout` out 1 each: register-file select and strobes.
- `MD_Read`, `ReadRAM`, `WriteRAM` out 1 each: MDR source and RAM strobes.
- `Control_Signals` out 5: ALU op code; 0 when unused.
- `run` out 1: 1 while executing, 0 in RESET or HALT.

## Operation
- States: RESET, T0–T7, HALT.
- All outputs are decoded from the registered state and `ir` only, with no combinational path from `con_ff` except at br T6.
- Fetch, common to every instruction:
  - T0: busSelect[20], enable[25], Control_Signals=OP_INC, enable[18].
  - T1: busSelect[19], enable[20], enable[21], MD_Read, ReadRAM.
  - T2: busSelect[21], enable[24].
- Decode is taken from `ir` in T3. Execute sequences by opcode:
  - add 00011, sub 00100, and 00101, or 00110:
    - T3 Grb, Rout, busSelect[0], Yin.
    - T4 Grc, Rout, busSelect[0], Control_Signals=opcode, Zin.
    - T5 busSelect[19], Gra, Rin.
  - addi 01100:
    - T3 as R-type.
    - T4 busSelect[23], Control_Signals=OP_ADD, Zin.
    - T5 busSelect[19], Gra, Rin.
  - ld 00000:
    - T3 Grb, BAout, Yin.
    - T4 busSelect[23], OP_ADD, Zin.
    - T5 busSelect[19], MARin.
    - T6 MD_Read, ReadRAM, MDRin.
    - T7 busSelect[21], Gra, Rin.
  - st 00010:
    - T3–T5 as ld.
    - T6 Gra, Rout, busSelect[0], MDRin with MD_Read=0.
    - T7 WriteRAM.
  - jr 10100: T3 Gra, Rout, busSelect[0], PCin.
  - br 10010:
    - T3 Gra, Rout, busSelect[0], CONin.
    - T4 busSelect[20], Yin.
    - T5 busSelect[23], OP_ADD, Zin.
    - T6 busSelect[19]; PCin is asserted only if `con_ff`=1.
  - nop 11001 and every unlisted opcode: T3 asserts nothing.
  - halt 11010: T3 goes to HALT.
- The last execute state of each instruction returns to T0.
- HALT holds until `clr` is asserted; all outputs are 0 and `run`=0.

## Timing
- Asserting `clr` forces RESET immediately. All outputs are 0 and `run`=0, including when reset lands mid-instruction; no partial write completes.
- First rising edge after `clr` deasserts: RESET→T0. The fetch of PC begins in that cycle.
- Each state lasts exactly one clock unless stalled (see Configuration).
- Instruction latency from T0 entry to the next T0:
  - R-type and addi: 6 cycles.
  - ld, st: 8 cycles.
  - jr, nop: 4 cycles.
  - br: 7 cycles.
- `busSelect` is at most one-hot in every state. Rin and Rout are never both 1.

## Configuration
- `CU_MEM_WAIT_EN` defined: states T1 (fetch read), ld T6 and st T7 hold, with their outputs held, until a rising edge samples `mem_ready`=1; then advance.
- `CU_MEM_WAIT_EN` undefined: `mem_ready` is ignored and every RAM state lasts one cycle.

## Test plan
- Reset: pulse `clr`=0 during st T6 → all outputs 0 at once. After release, the next state is T0 with busSelect=0x00100000, enable=0x02040000, Control_Signals=14.
- Fetch plus add: `ir`=0x18000000 (add) → T0–T5 strobes as listed. T4 Control_Signals=3; T5 Rin=1, Gra=1. T0 returns after 6 cycles.
- ld: `ir`=0x00800005 → T6 has MD_Read=ReadRAM=enable[21]=1; T7 has busSelect[21]=1 and Rin=1. Total 8 cycles.
- br: `ir`=0x90000010 with `con_ff`=0 → T6 enable[20]=0. Repeat with `con_ff`=1 → T6 enable[20]=1.
- halt: `ir`=0xD0000000 → HALT after T3, `run`=0, outputs 0 for 20 cycles. `clr` pulse → resumes at T0.
- With `CU_MEM_WAIT_EN` and `mem_ready`=0 for 3 cycles at T1 → T1 outputs held for 4 cycles total, then T2.
